// File: rtl/adder_sched.sv
// adder_sched: control-path scheduler that gates MUL results into the ADDER tree,
// bounds in-flight rounds and tracks in-order Psum returns. Optional macro: ADDER_SCHED_TIMEOUT_EN.
module adder_sched #(
  parameter int MAX_OUT = 2
`ifdef ADDER_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic       clk,
  input  logic       rst,
  // Handshakes: a transfer happens in any cycle where valid and ready are both high;
  // ready never depends on valid, and valid is not required to wait for ready.
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_wsize,
  input  logic       cfg_stride,
  input  logic [2:0] cfg_nround,
  input  logic       mul_valid,
  output logic       mul_ready,
  output logic [3:0] add_wsize,
  output logic       add_stride,
  output logic [2:0] add_wround,
  output logic       add_data_valid,
  input  logic       add_psum_valid,
  output logic [2:0] psum_tag,
  output logic       job_done,
  output logic       busy,
  output logic       err_cfg,
  output logic       err_spurious,
`ifdef ADDER_SCHED_TIMEOUT_EN
  output logic       err_timeout,
`endif
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] LP_MAX_OUT = 3'(MAX_OUT);

  logic [1:0] r_state;
  logic [3:0] r_iss;
  logic [3:0] r_ret;
  logic [2:0] r_out;
  logic [2:0] r_nround;
  logic [3:0] r_wsize;
  logic       r_stride;
  logic       r_err_cfg;
  logic       r_err_spur;

  logic [1:0] w_state_next;
  logic [3:0] w_iss_next;
  logic [3:0] w_ret_next;
  logic [2:0] w_out_upd;
  logic [2:0] w_out_next;
  logic       w_cfg_legal;
  logic       w_cfg_accept;
  logic       w_cfg_reject;
  logic       w_issue;
  logic       w_return;
  logic       w_spurious;
  logic       w_last_issued;
  logic       w_timeout;
  logic       w_unused_ret;

  assign w_cfg_legal  = (cfg_wsize == 4'd1) || (cfg_wsize == 4'd3) ||
                        (cfg_wsize == 4'd5) || (cfg_wsize == 4'd7);
  assign w_cfg_accept = (r_state == S_IDLE) && cfg_valid && w_cfg_legal;
  assign w_cfg_reject = (r_state == S_IDLE) && cfg_valid && !w_cfg_legal;

  assign mul_ready = (r_state == S_RUN) && (r_out < LP_MAX_OUT) &&
                     (r_iss <= {1'b0, r_nround});
  assign w_issue   = mul_valid && mul_ready;

  // Returns are strictly in order, so the return counter alone names the round.
  assign w_return   = add_psum_valid && (r_out != 3'd0);
  assign w_spurious = add_psum_valid && (r_out == 3'd0);

  assign w_last_issued = (r_iss == ({1'b0, r_nround} + 4'd1));

  assign cfg_ready      = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign job_done       = (r_state == S_DONE);
  assign add_data_valid = w_issue;
  assign add_wround     = r_iss[2:0];
  assign add_wsize      = r_wsize;
  assign add_stride     = r_stride;
  assign psum_tag       = r_ret[2:0];
  assign err_cfg        = r_err_cfg;
  assign err_spurious   = r_err_spur;
  assign dbg_state      = r_state;
  assign w_unused_ret   = r_ret[3];

  always_comb begin
    w_iss_next = r_iss;
    w_ret_next = r_ret;
    w_out_upd  = r_out;
    if (w_issue) begin
      w_iss_next = r_iss + 4'd1;
    end
    if (w_return) begin
      w_ret_next = r_ret + 4'd1;
    end
    case ({w_issue, w_return})
      2'b10:   w_out_upd = r_out + 3'd1;
      2'b01:   w_out_upd = r_out - 3'd1;
      default: w_out_upd = r_out;
    endcase
    w_out_next = w_out_upd;
    if (w_cfg_accept || w_timeout) begin
      w_iss_next = 4'd0;
      w_ret_next = 4'd0;
      w_out_next = 3'd0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cfg_accept) w_state_next = S_RUN;
      S_RUN:   if (w_last_issued) w_state_next = S_DRAIN;
      S_DRAIN: if (w_out_upd == 3'd0) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (w_timeout) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_iss      <= 4'd0;
      r_ret      <= 4'd0;
      r_out      <= 3'd0;
      r_nround   <= 3'd0;
      r_wsize    <= 4'd0;
      r_stride   <= 1'b0;
      r_err_cfg  <= 1'b0;
      r_err_spur <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_iss     <= w_iss_next;
      r_ret     <= w_ret_next;
      r_out     <= w_out_next;
      r_err_cfg <= w_cfg_reject;
      if (w_spurious) begin
        r_err_spur <= 1'b1;
      end
      if (w_cfg_accept) begin
        r_nround <= cfg_nround;
        r_wsize  <= cfg_wsize;
        r_stride <= cfg_stride;
      end
    end
  end

`ifdef ADDER_SCHED_TIMEOUT_EN
  logic [15:0] r_idle_cnt;
  logic        r_err_timeout;
  logic        w_to_count;

  // Only stalls with work outstanding count; any handshake restarts the window.
  assign w_to_count  = ((r_state == S_RUN) || (r_state == S_DRAIN)) &&
                       (r_out != 3'd0) && !w_issue && !w_return;
  assign w_timeout   = w_to_count && (r_idle_cnt == 16'(TIMEOUT_CYC - 1));
  assign err_timeout = r_err_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle_cnt    <= 16'd0;
      r_err_timeout <= 1'b0;
    end else begin
      if (!w_to_count || w_timeout) begin
        r_idle_cnt <= 16'd0;
      end else begin
        r_idle_cnt <= r_idle_cnt + 16'd1;
      end
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_adder_sched.sv
// Directed self-checking bench for adder_sched (MAX_OUT=2); timeout scenario only
// when ADDER_SCHED_TIMEOUT_EN is defined.
module tb_adder_sched;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_wsize;
  logic       cfg_stride;
  logic [2:0] cfg_nround;
  logic       mul_valid;
  logic       mul_ready;
  logic [3:0] add_wsize;
  logic       add_stride;
  logic [2:0] add_wround;
  logic       add_data_valid;
  logic       add_psum_valid;
  logic [2:0] psum_tag;
  logic       job_done;
  logic       busy;
  logic       err_cfg;
  logic       err_spurious;
  logic [1:0] dbg_state;
`ifdef ADDER_SCHED_TIMEOUT_EN
  logic       err_timeout;
`endif

  int checks = 0;
  int errors = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  adder_sched #(
    .MAX_OUT(2)
`ifdef ADDER_SCHED_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_wsize(cfg_wsize),
    .cfg_stride(cfg_stride), .cfg_nround(cfg_nround),
    .mul_valid(mul_valid), .mul_ready(mul_ready),
    .add_wsize(add_wsize), .add_stride(add_stride), .add_wround(add_wround),
    .add_data_valid(add_data_valid), .add_psum_valid(add_psum_valid),
    .psum_tag(psum_tag), .job_done(job_done), .busy(busy),
    .err_cfg(err_cfg), .err_spurious(err_spurious),
`ifdef ADDER_SCHED_TIMEOUT_EN
    .err_timeout(err_timeout),
`endif
    .dbg_state(dbg_state)
  );

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer_cfg(input logic [3:0] ws, input logic st, input logic [2:0] nr);
    cfg_valid  = 1'b1;
    cfg_wsize  = ws;
    cfg_stride = st;
    cfg_nround = nr;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_wsize = 4'd0; cfg_stride = 1'b0;
    cfg_nround = 3'd0; mul_valid = 1'b0; add_psum_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    settle();

    // reset state
    chk("rst_cfg_ready", 16'(cfg_ready), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_mul_ready", 16'(mul_ready), 16'd0);
    chk("rst_add_wsize", 16'(add_wsize), 16'd0);
    chk("rst_flags", {13'd0, job_done, err_cfg, err_spurious}, 16'd0);
    chk("rst_state", 16'(dbg_state), 16'd0);

    // single-round job: issue, return two cycles later, done
    offer_cfg(4'd3, 1'b1, 3'd0);
    tick();
    cfg_valid = 1'b0;
    settle();
    chk("t1_busy", 16'(busy), 16'd1);
    chk("t1_cfg_ready", 16'(cfg_ready), 16'd0);
    chk("t1_latched", {11'd0, add_stride, add_wsize}, 16'h0013);
    mul_valid = 1'b1;
    settle();
    chk("t1_adv", 16'(add_data_valid), 16'd1);
    chk("t1_wround", 16'(add_wround), 16'd0);
    tick();
    mul_valid = 1'b0;
    settle();
    chk("t1_ready_after_last", 16'(mul_ready), 16'd0);
    tick();
    add_psum_valid = 1'b1;
    settle();
    chk("t1_tag", 16'(psum_tag), 16'd0);
    chk("t1_not_done_yet", 16'(job_done), 16'd0);
    tick();
    add_psum_valid = 1'b0;
    settle();
    chk("t1_job_done", 16'(job_done), 16'd1);
    tick();
    chk("t1_done_pulse", 16'(job_done), 16'd0);
    chk("t1_idle", 16'(busy), 16'd0);
    chk("t1_no_spurious", 16'(err_spurious), 16'd0);

    // four rounds with MAX_OUT=2, then issue and return together
    offer_cfg(4'd5, 1'b0, 3'd3);
    tick();
    cfg_valid = 1'b0;
    mul_valid = 1'b1;
    settle();
    chk("t2_adv0", 16'(add_data_valid), 16'd1);
    chk("t2_wround0", 16'(add_wround), 16'd0);
    tick();
    chk("t2_adv1", 16'(add_data_valid), 16'd1);
    chk("t2_wround1", 16'(add_wround), 16'd1);
    tick();
    chk("t2_stall_ready", 16'(mul_ready), 16'd0);
    chk("t2_stall_adv", 16'(add_data_valid), 16'd0);
    offer_cfg(4'd1, 1'b1, 3'd0);
    tick();
    cfg_valid = 1'b0;
    settle();
    chk("t2_cfg_ignored", {11'd0, add_stride, add_wsize}, 16'h0005);
    chk("t2_stall_ready2", 16'(mul_ready), 16'd0);
    add_psum_valid = 1'b1;
    settle();
    chk("t2_tag0", 16'(psum_tag), 16'd0);
    chk("t2_ready_same_cycle", 16'(mul_ready), 16'd0);
    tick();
    settle();
    chk("t3_ready", 16'(mul_ready), 16'd1);
    chk("t3_wround2", 16'(add_wround), 16'd2);
    chk("t3_tag1", 16'(psum_tag), 16'd1);
    tick();
    add_psum_valid = 1'b0;
    settle();
    chk("t3_wround3", 16'(add_wround), 16'd3);
    chk("t3_adv_out_held", 16'(add_data_valid), 16'd1);
    tick();
    mul_valid = 1'b0;
    settle();
    chk("t2_all_issued", 16'(mul_ready), 16'd0);
    add_psum_valid = 1'b1;
    settle();
    chk("t2_tag2", 16'(psum_tag), 16'd2);
    tick();
    chk("t2_tag3", 16'(psum_tag), 16'd3);
    chk("t2_drain", 16'(dbg_state), 16'd2);
    tick();
    add_psum_valid = 1'b0;
    settle();
    chk("t2_job_done", 16'(job_done), 16'd1);
    tick();
    chk("t2_idle", 16'(busy), 16'd0);
    chk("t2_no_spurious", 16'(err_spurious), 16'd0);

    // illegal wsize, then a return while idle
    offer_cfg(4'd4, 1'b0, 3'd0);
    tick();
    cfg_valid = 1'b0;
    settle();
    chk("t4_err_cfg", 16'(err_cfg), 16'd1);
    chk("t4_cfg_ready", 16'(cfg_ready), 16'd1);
    chk("t4_busy", 16'(busy), 16'd0);
    tick();
    chk("t4_err_cfg_pulse", 16'(err_cfg), 16'd0);
    add_psum_valid = 1'b1;
    tick();
    add_psum_valid = 1'b0;
    settle();
    chk("t4_spurious", 16'(err_spurious), 16'd1);
    tick(); tick();
    chk("t4_spurious_sticky", 16'(err_spurious), 16'd1);

    // reset in DRAIN with two rounds outstanding
    offer_cfg(4'd7, 1'b0, 3'd1);
    tick();
    cfg_valid = 1'b0;
    mul_valid = 1'b1;
    tick(); tick();
    mul_valid = 1'b0;
    tick();
    chk("t5_in_drain", 16'(dbg_state), 16'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mul_valid = 1'b1;
    settle();
    chk("t5_idle", 16'(dbg_state), 16'd0);
    chk("t5_busy", 16'(busy), 16'd0);
    chk("t5_adv", 16'(add_data_valid), 16'd0);
    chk("t5_spur_cleared", 16'(err_spurious), 16'd0);
    chk("t5_wsize_cleared", 16'(add_wsize), 16'd0);
    mul_valid = 1'b0;
    add_psum_valid = 1'b1;
    tick();
    add_psum_valid = 1'b0;
    settle();
    chk("t5_late_psum", 16'(err_spurious), 16'd1);

`ifdef ADDER_SCHED_TIMEOUT_EN
    // one issue, never returned: abort after 16 stalled cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    offer_cfg(4'd1, 1'b0, 3'd0);
    tick();
    cfg_valid = 1'b0;
    mul_valid = 1'b1;
    tick();
    mul_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    chk("t6_no_timeout_yet", 16'(err_timeout), 16'd0);
    chk("t6_still_busy", 16'(busy), 16'd1);
    tick();
    chk("t6_timeout", 16'(err_timeout), 16'd1);
    chk("t6_idle", 16'(dbg_state), 16'd0);
    chk("t6_no_done", 16'(job_done), 16'd0);
    tick();
    chk("t6_sticky", 16'(err_timeout), 16'd1);
    chk("t6_no_done_after", 16'(job_done), 16'd0);
`endif

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
